// File: rtl/colour_decoder.sv
// Four-colour button decoder: sync, debounce, press FSM and a buffered valid/ready code output.
// Define COLOUR_DEC_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module colour_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] btn_in,
  output logic [1:0] colour_dec_out,
  output logic       dec_valid,
  input  logic       dec_ready,
  output logic       multi_err,
  output logic       overflow
);

  localparam int unsigned BTN_W  = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || FIFO_DEPTH < 2) begin : g_param_check
    $error("colour_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HELD, BAD} state_t;

  logic [BTN_W-1:0]  sync1_q, sync2_q, sync3_q, pat_q;
  logic [CNT_W-1:0]  cnt_q;
  state_t            state_q, state_d;
  logic [BTN_W-1:0]  held_q, held_d;
  logic              multi_d;
  logic              push_c, pop_c, full_c, accept_c;
  logic              pat_zero_c, pat_onehot_c;
  logic [CODE_W-1:0] code_c;

  // Synchroniser always samples; the stability counter and pattern freeze when ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      if (ena) begin
        sync3_q <= sync2_q;
        if (sync2_q != sync3_q) begin
          cnt_q <= '0;
        end else begin
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_LOAD) pat_q <= sync2_q;
        end
      end
    end
  end

  assign pat_zero_c   = (pat_q == '0);
  assign pat_onehot_c = !pat_zero_c && ((pat_q & (pat_q - BTN_W'(1))) == '0);

  always_comb begin
    code_c = 2'b00;
    unique case (pat_q)
      4'b0010: code_c = 2'b01;
      4'b0100: code_c = 2'b10;
      4'b1000: code_c = 2'b11;
      default: code_c = 2'b00;
    endcase
  end

  // Press FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      held_q    <= '0;
      multi_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      multi_err <= multi_d;
    end
  end

  // One push per press; a changed or multi-hot pattern parks in BAD until full release
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    multi_d = 1'b0;
    push_c  = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (pat_onehot_c) begin
            push_c  = 1'b1;
            held_d  = pat_q;
            state_d = HELD;
          end else if (!pat_zero_c) begin
            multi_d = 1'b1;
            state_d = BAD;
          end
        end
        HELD: begin
          if (pat_zero_c)            state_d = IDLE;
          else if (pat_q != held_q)  state_d = BAD;
        end
        BAD: begin
          if (pat_zero_c) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pop frees a slot before the push is judged, so a same-edge push into a full buffer fits
  assign pop_c    = dec_valid && dec_ready;
  assign accept_c = push_c && (!full_c || pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_c && full_c && !pop_c) begin
      overflow <= 1'b1;
    end
  end

`ifdef COLOUR_DEC_FIFO_EN
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTF_W = PTR_W + 1;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNTF_W-1:0] count_q;

  assign full_c = (count_q == CNTF_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept_c) begin
        mem_q[wr_ptr_q] <= code_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({accept_c, pop_c})
        2'b10:   count_q <= count_q + CNTF_W'(1);
        2'b01:   count_q <= count_q - CNTF_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign colour_dec_out = mem_q[rd_ptr_q];
  assign dec_valid      = (count_q != '0);
`else
  logic [CODE_W-1:0] hold_q;
  logic              hold_vld_q;

  assign full_c = hold_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (accept_c) begin
      hold_q     <= code_c;
      hold_vld_q <= 1'b1;
    end else if (pop_c) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign colour_dec_out = hold_q;
  assign dec_valid      = hold_vld_q;
`endif

endmodule

// File: tb/tb_colour_decoder.sv
// Self-checking bench for colour_decoder: directed vector table, hand sequences and a
// randomized run against a history-window reference model.
`timescale 1ns/1ps
module tb_colour_decoder;

  localparam int unsigned DEB = 4;
`ifdef COLOUR_DEC_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] btn_in = 4'b0000;
  logic [1:0] colour_dec_out;
  logic       dec_valid;
  logic       dec_ready = 1'b0;
  logic       multi_err;
  logic       overflow;

  colour_decoder #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn_in),
    .colour_dec_out(colour_dec_out), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .multi_err(multi_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sampled-button history, press mode, delivery queue
  int m_q[$];
  int m_hist[$];
  int m_deb, m_mode, m_held;
  bit m_multi, m_ovf;
  bit model_on = 1'b0;
  int got[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(int p);
    for (int b = 0; b < 4; b++) if (p == (1 << b)) return b;
    return 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hist.delete();
    repeat (DEB + 3) m_hist.push_back(0);
    m_deb = 0; m_mode = 0; m_held = 0; m_multi = 0; m_ovf = 0;
  endtask

  // A pattern is accepted once it filled D+1 consecutive samples, ignoring the two sync stages
  task automatic model_edge();
    bit push = 1'b0;
    bit same = 1'b1;
    int ones = $countones(m_deb);
    m_multi = 1'b0;
    case (m_mode)
      0: if (ones == 1) begin push = 1'b1; m_held = m_deb; m_mode = 1; end
         else if (ones > 1) begin m_multi = 1'b1; m_mode = 2; end
      1: if (ones == 0) m_mode = 0; else if (m_deb != m_held) m_mode = 2;
      default: if (ones == 0) m_mode = 0;
    endcase
    if (m_q.size() > 0 && dec_ready) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(code_of(m_deb));
      else m_ovf = 1'b1;
    end
    m_hist.push_back(int'(btn_in));
    void'(m_hist.pop_front());
    for (int i = 1; i <= DEB; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
    if (same) m_deb = m_hist[0];
  endtask

  task automatic model_compare();
    check("valid", int'(dec_valid), int'(m_q.size() > 0));
    if (m_q.size() > 0) check("code", int'(colour_dec_out), m_q[0]);
    check("multi_err", int'(multi_err), int'(m_multi));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic step();
    if (dec_valid && dec_ready) got.push_back(int'(colour_dec_out));
    @(posedge clk);
    if (model_on) model_edge();
    #1;
    if (model_on) model_compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(dec_valid), 0);
    check("rst_code", int'(colour_dec_out), 0);
    check("rst_multi", int'(multi_err), 0);
    check("rst_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    got.delete();
  endtask

  task automatic press(int code, int hold, int rel);
    btn_in = 4'(1 << code);
    repeat (hold) step();
    btn_in = 4'b0000;
    repeat (rel) step();
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         exp_at;
    int         exp_code;
    int         exp_multi;
  } vec_t;

  vec_t vecs[9];
  int   seq[5];

  initial begin
    int first, nval, nmulti, code;

    vecs[0] = '{4'b0100, 10, 8, 2, 0};
    vecs[1] = '{4'b0001, 10, 8, 0, 0};
    vecs[2] = '{4'b0010, 10, 8, 1, 0};
    vecs[3] = '{4'b1000, 10, 8, 3, 0};
    vecs[4] = '{4'b0011,  8, 0, 0, 1};
    vecs[5] = '{4'b1100,  8, 0, 0, 1};
    vecs[6] = '{4'b1111,  8, 0, 0, 1};
    vecs[7] = '{4'b0001,  5, 8, 0, 0};
    vecs[8] = '{4'b1000,  4, 0, 0, 0};
    seq = '{0, 1, 2, 3, 0};

    #2;
    do_reset();
    model_on = 1'b1;

    // Vector table: latency, code, single-cycle valid, multi-hot pulse, hold-length boundary
    foreach (vecs[v]) begin
      btn_in = vecs[v].btn; dec_ready = 1'b1;
      first = 0; nval = 0; nmulti = 0; code = -1;
      for (int i = 1; i <= vecs[v].hold + 14; i++) begin
        step();
        if (i == vecs[v].hold) btn_in = 4'b0000;
        if (dec_valid) begin
          nval++;
          if (first == 0) begin first = i; code = int'(colour_dec_out); end
        end
        if (multi_err) nmulti++;
      end
      check($sformatf("vec%0d_latency", v), first, vecs[v].exp_at);
      check($sformatf("vec%0d_nvalid", v), nval, (vecs[v].exp_at != 0) ? 1 : 0);
      if (vecs[v].exp_at != 0) check($sformatf("vec%0d_code", v), code, vecs[v].exp_code);
      check($sformatf("vec%0d_multi", v), nmulti, vecs[v].exp_multi);
    end

    // Bounce shorter than the debounce window is ignored
    got.delete();
    for (int i = 0; i < 20; i++) begin
      btn_in = (((i / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
      step();
    end
    btn_in = 4'b0000;
    repeat (10) step();
    check("bounce_none", got.size(), 0);
    press(0, 8, 12);
    check("bounce_then_press_n", got.size(), 1);
    if (got.size() > 0) check("bounce_then_press_code", got[0], 0);

    // Back-pressure: ordering and overflow
    do_reset();
    dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      press(seq[k], 8, 10);
      check($sformatf("bp_ovf_after_%0d", k + 1), int'(overflow), (k + 1 > DEPTH) ? 1 : 0);
    end
    dec_ready = 1'b1;
    repeat (10) step();
    check("bp_count", got.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < got.size(); k++) check($sformatf("bp_order%0d", k), got[k], seq[k]);

    // Full buffer: pop and push on the same edge
    do_reset();
    dec_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) press(seq[k], 8, 10);
    check("full_pre_ovf", int'(overflow), 0);
    btn_in = 4'b1000;
    repeat (7) step();
    dec_ready = 1'b1;
    step();
    check("full_same_edge_ovf", int'(overflow), 0);
    btn_in = 4'b0000;
    repeat (12) step();
    check("full_same_edge_count", got.size(), DEPTH + 1);
    if (got.size() > 0) begin
      check("full_same_edge_first", got[0], 0);
      check("full_same_edge_last", got[got.size() - 1], 3);
    end

    // Reset mid-operation with a button held through it
    do_reset();
    dec_ready = 1'b0;
    press(0, 8, 10);
    press(1, 8, 10);
    btn_in = 4'b0010;
    repeat (3) step();
    check("pre_rst_valid", int'(dec_valid), 1);
    do_reset();
    dec_ready = 1'b1; first = 0; code = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (dec_valid && first == 0) begin first = i; code = int'(colour_dec_out); end
    end
    check("post_rst_latency", first, 8);
    check("post_rst_code", code, 1);
    btn_in = 4'b0000;
    repeat (10) step();

    // ena low freezes decoding but still allows pops
    do_reset();
    model_on = 1'b0;
    ena = 1'b0; dec_ready = 1'b0; btn_in = 4'b0001; nval = 0;
    repeat (20) begin step(); if (dec_valid) nval++; end
    check("ena_low_no_push", nval, 0);
    ena = 1'b1; first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin step(); if (dec_valid) first = i; end
    check("ena_resume_latency", first, 6);
    check("ena_resume_code", int'(colour_dec_out), 0);
    ena = 1'b0; dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("ena_low_pop", int'(dec_valid), 0);
    ena = 1'b1; btn_in = 4'b0000;

    // Randomized run against the reference model
    do_reset();
    model_on = 1'b1;
    for (int s = 0; s < 150; s++) begin
      int kind = int'($urandom_range(0, 3));
      int hold = int'($urandom_range(1, 12));
      if (kind == 0) btn_in = 4'b0000;
      else if (kind == 3) btn_in = 4'($urandom_range(0, 15));
      else btn_in = 4'(1 << $urandom_range(0, 3));
      repeat (hold) begin
        dec_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
